// File: rtl/cla_pkg.sv
// cla_pkg: shared constants for the pipelined carry-lookahead adder.
//   WIDTH_DEF - default operand width
//   GRP       - bits per lookahead group
//   SGRP      - bits per supergroup (carries ripple between supergroups)
package cla_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int GRP = 4;
    localparam int SGRP = 16;
endpackage

// File: rtl/cla_add_pipe_if.sv
// cla_add_pipe_if: valid/ready operand and result bus of the pipelined adder.
//   master: drives in_valid, a, b, cin, sub, out_ready
//   slave : drives in_ready, out_valid, sum, cout, ovf, zero
interface cla_add_pipe_if import cla_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input in_ready, out_valid, sum, cout, ovf, zero);
    modport slave (input in_valid, a, b, cin, sub, out_ready,
                   output in_ready, out_valid, sum, cout, ovf, zero);
endinterface

// File: rtl/cla_pg4.sv
// cla_pg4: 4-input carry-lookahead unit.
//   p, g : propagate/generate of the four inputs (bits or groups)
//   ci   : carry into input 0
//   c    : c[k] is the carry out of input k-1
//   gp,gg: propagate/generate of the whole block
module cla_pg4 (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       ci,
    output logic [4:1] c,
    output logic       gp,
    output logic       gg
);
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & ci);
    assign gg   = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]);
    assign gp   = &p;
    assign c[4] = gg | (gp & ci);
endmodule

// File: rtl/cla_add_pipe.sv
// cla_add_pipe: two-stage pipelined carry-lookahead adder/subtractor.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of cla_add_pipe_if (operands in, result out)
// Stage 1 registers bit and group propagate/generate; stage 2 resolves
// carries (lookahead within 16-bit supergroups, ripple between them).
module cla_add_pipe import cla_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
    input logic clk,
    input logic rst_n,
    cla_add_pipe_if.slave bus
);
    localparam int NG = WIDTH / GRP;
    localparam int NS = WIDTH / SGRP;
    localparam int GPS = SGRP / GRP;
    logic [WIDTH-1:0] bx, p_d, g_d;
    logic [NG-1:0] gp_d, gg_d;
    logic [4*NG-1:0] unused_c1;
    logic s1_valid, s2_adv, in_ready, in_fire, s1_fire;
    logic [WIDTH-1:0] s1_p, s1_g;
    logic [NG-1:0] s1_gp, s1_gg;
    logic s1_c0;
    logic [NG:0] gc;
    logic [WIDTH:0] bc;
    logic [NG-1:0] unused_bc, unused_bp, unused_bg;
    logic [NS-1:0] unused_sp, unused_sg;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic out_valid, cout_q, ovf_q, zero_q;
    assign bx = bus.sub ? ~bus.b : bus.b;
    assign p_d = bus.a ^ bx;
    assign g_d = bus.a & bx;
    // Only group p/g are needed in stage 1; the carries come later.
    for (genvar i = 0; i < NG; i++) begin : g_s1
        cla_pg4 u_grp (
            .p(p_d[GRP*i +: GRP]), .g(g_d[GRP*i +: GRP]), .ci(1'b0),
            .c(unused_c1[4*i +: 4]), .gp(gp_d[i]), .gg(gg_d[i])
        );
    end
    assign s2_adv = !out_valid || bus.out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign in_fire = bus.in_valid && in_ready;
    assign s1_fire = s1_valid && s2_adv;
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_p  <= p_d;
            s1_g  <= g_d;
            s1_gp <= gp_d;
            s1_gg <= gg_d;
            s1_c0 <= bus.sub | bus.cin;
        end
    end
    // Group carries: c[4] of each supergroup unit ripples into the next one.
    assign gc[0] = s1_c0;
    for (genvar s = 0; s < NS; s++) begin : g_sg
        cla_pg4 u_sg (
            .p(s1_gp[GPS*s +: GPS]), .g(s1_gg[GPS*s +: GPS]), .ci(gc[GPS*s]),
            .c(gc[GPS*s+GPS : GPS*s+1]), .gp(unused_sp[s]), .gg(unused_sg[s])
        );
    end
    // Bit carries inside each group; the group's carry-out comes from gc.
    for (genvar j = 0; j < NG; j++) begin : g_bit
        assign bc[GRP*j] = gc[j];
        cla_pg4 u_bit (
            .p(s1_p[GRP*j +: GRP]), .g(s1_g[GRP*j +: GRP]), .ci(gc[j]),
            .c({unused_bc[j], bc[GRP*j+3 : GRP*j+1]}),
            .gp(unused_bp[j]), .gg(unused_bg[j])
        );
    end
    assign bc[WIDTH] = gc[NG];
    assign sum_d = s1_p ^ bc[WIDTH-1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            s1_valid <= in_fire ? 1'b1 : (s2_adv ? 1'b0 : s1_valid);
            if (s2_adv) out_valid <= s1_valid;
            if (s1_fire) begin
                sum_q  <= sum_d;
                cout_q <= bc[WIDTH];
                ovf_q  <= bc[WIDTH] ^ bc[WIDTH-1];
                zero_q <= ~|sum_d;
            end
        end
    end
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla_add_pipe.sv
// tb_cla_add_pipe: self-checking bench for cla_add_pipe against an arithmetic model.
module tb_cla_add_pipe;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_fail = 0;
    int run = 0;
    int max_run = 0;
    logic [W+2:0] q[$];
    logic prev_hold = 1'b0;
    logic [W+2:0] prev_res;
    cla_add_pipe_if #(.WIDTH(W)) bus();
    cla_add_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // Result packed as {ovf, zero, cout, sum}.
    function automatic logic [W+2:0] model(input logic [W-1:0] a, b, input logic cin, sub);
        logic [W-1:0] bb;
        logic [W:0] full;
        logic ov;
        bb = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub ? 1'b1 : cin};
        ov = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full[W-1:0] == '0, full[W], full[W-1:0]};
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask
    function automatic logic [W+2:0] dut_res();
        return {bus.ovf, bus.zero, bus.cout, bus.sum};
    endfunction
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_hold = 1'b0;
            run = 0;
        end else begin
            if (bus.out_valid) begin
                run++;
                if (run > max_run) max_run = run;
                if (prev_hold) chk("hold_stable", 64'(dut_res()), 64'(prev_res));
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out actual=%h required=none", dut_res());
                end else begin
                    chk("out_result", 64'(dut_res()), 64'(q[0]));
                    if (bus.out_ready) void'(q.pop_front());
                end
            end else run = 0;
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_res = dut_res();
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        end
    end
    task automatic send(input logic [W-1:0] va, vb, input logic vc, vs);
        int t = 0;
        bus.a = va;
        bus.b = vb;
        bus.cin = vc;
        bus.sub = vs;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
        end
        @(posedge clk);
        #1;
    endtask
    task automatic one(input logic [W-1:0] va, vb, input logic vc, vs, input logic [W+2:0] exp);
        send(va, vb, vc, vs);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("latency_early", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("latency_valid", 64'(bus.out_valid), 64'd1);
        chk("literal_result", 64'(dut_res()), 64'(exp));
        @(posedge clk);
        #1;
    endtask
    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || bus.out_valid) && t < 100) begin
            t++;
            @(negedge clk);
        end
        chk("drained", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask
    logic [W-1:0] sa[8] = '{32'h12345678, 32'hFFFFFFFF, 32'h80000000, 32'h00000000,
                            32'hDEADBEEF, 32'h7FFFFFFF, 32'h0000FFFF, 32'hAAAAAAAA};
    logic [W-1:0] sb[8] = '{32'h87654321, 32'h00000001, 32'h80000000, 32'h00000000,
                            32'h21524111, 32'hFFFFFFFF, 32'h00000001, 32'h55555555};
    logic [7:0] sc = 8'b0110_1001;
    logic [7:0] ss = 8'b1010_1100;
    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        chk("model_1p1", 64'(model(32'h1, 32'h1, 1'b0, 1'b0)), 64'({3'b000, 32'h00000002}));
        chk("model_ripple", 64'(model(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0)), 64'({3'b011, 32'h00000000}));
        chk("model_addovf", 64'(model(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0)), 64'({3'b100, 32'h80000000}));
        chk("model_subovf", 64'(model(32'h80000000, 32'h1, 1'b0, 1'b1)), 64'({3'b101, 32'h7FFFFFFF}));
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(dut_res()), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        one(32'h00000001, 32'h00000001, 1'b0, 1'b0, {3'b000, 32'h00000002});
        one(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, {3'b011, 32'h00000000});
        one(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {3'b100, 32'h80000000});
        one(32'h80000000, 32'h00000001, 1'b0, 1'b1, {3'b101, 32'h7FFFFFFF});
        one(32'h00000005, 32'h00000005, 1'b1, 1'b1, {3'b011, 32'h00000000});
        max_run = 0;
        for (int i = 0; i < 8; i++) send(sa[i], sb[i], sc[i], ss[i]);
        bus.in_valid = 1'b0;
        drain();
        chk("stream_run", 64'(max_run), 64'd8);
        bus.out_ready = 1'b0;
        send(32'h00000010, 32'h00000020, 1'b0, 1'b0);
        send(32'h00000100, 32'h00000001, 1'b0, 1'b1);
        bus.a = 32'hCAFEF00D;
        bus.b = 32'h0BADBEEF;
        bus.cin = 1'b1;
        bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(32'hCAFEF00D, 32'h0BADBEEF, 1'b1, 1'b0);
        send(32'h00000000, 32'h00000001, 1'b0, 1'b1);
        send(32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        drain();
        bus.out_ready = 1'b0;
        send(32'h00000003, 32'h00000004, 1'b0, 1'b0);
        send(32'h00000009, 32'h00000002, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_result", 64'(dut_res()), 64'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("postrst_quiet", 64'(bus.out_valid), 64'd0);
        end
        chk("postrst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        one(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, {3'b000, 32'h00010000});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cla_add_pipe.md
CLA_ADD_PIPE -- requirements
Module: cla_add_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand width; SHALL be a multiple of 16.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operands and controls valid this cycle.
REQ-005 in_ready  output  1  block accepts an input when in_valid and in_ready are both high.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in; ignored when sub=1.
REQ-009 sub  input  1  1 = A-B (B inverted, carry-in forced to 1); 0 = A+B+cin.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer takes the result when out_valid and out_ready are both high.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of the MSB; for sub=1, 1 means no borrow.
REQ-014 ovf  output  1  signed overflow.
REQ-015 zero  output  1  sum equals 0.

Function
REQ-016 Two-stage pipeline; latency SHALL be exactly 2 cycles from input acceptance to out_valid when out_ready stays high.
REQ-017 Stage 1 SHALL register per-bit p=a^b', g=a&b' (b' = sub ? ~b : b), the effective carry-in, and the 4-bit group P/G for all WIDTH/4 groups.
REQ-018 Stage 2 SHALL compute group carries with 4-group lookahead units, ripple between 16-bit supergroups, then form sum, cout, ovf, zero and register them.
REQ-019 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-020 Throughput SHALL be one result per cycle while out_ready is high.
REQ-021 Stall: each stage register SHALL hold its contents while its valid bit is high and the downstream side is not ready; in_ready = !s1_valid || s2_advance, where s2_advance = !out_valid || out_ready.
REQ-022 Simultaneous accept and drain SHALL be allowed in the same cycle at both stages, without bubbles or loss.
REQ-023 sum, cout, ovf and zero SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 Carry out of the WIDTH-bit result SHALL be dropped from sum (modulo 2^WIDTH); no wider result is produced.

Reset
REQ-025 On rst_n low: out_valid=0, both stage valid bits=0, sum=0, cout=0, ovf=0, zero=0; in_ready SHALL read 1 once rst_n is high.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight results; no output SHALL appear after rst_n is released without a new input.
REQ-027 Data registers other than the outputs need not be reset; valid bits gate them.

Structure
REQ-028 Package cla_pkg SHALL hold the default WIDTH, the group size 4, and the supergroup size 16 as constants.
REQ-029 One sub-module, cla_pg4, SHALL implement 4-input lookahead: inputs P[3:0], G[3:0], C; outputs c[4:1] and group p/g. It SHALL be instantiated for both bit-group and group-of-group levels.
REQ-030 No latches and no combinational path from in_valid to out_valid; out_ready SHALL reach in_ready only through REQ-021 logic.

Verification
REQ-031 Reset, then a=0x00000001, b=0x00000001, sub=0, cin=0, out_ready=1 -> 2 cycles later out_valid=1, sum=0x00000002, cout=0, ovf=0, zero=0.
REQ-032 a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, zero=1, ovf=0 (full carry ripple across all groups).
REQ-033 a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, ovf=1. a=0x80000000, b=0x00000001, sub=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
REQ-034 Back-to-back stream of 8 inputs, out_ready=1 -> 8 consecutive out_valid cycles in input order, results matching a reference model.
REQ-035 Hold out_ready=0 for 4 cycles while streaming inputs -> in_ready falls after 2 accepted inputs, outputs stay stable, and all results drain in order when out_ready returns to 1.
REQ-036 Deassert rst_n while 2 results are in flight -> out_valid=0 immediately; no stale result appears after release.
